// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
package div_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_CNT_W = 6;

  // Quotient returned for a zero divisor, and the most negative signed value.
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/div_negate.sv
// Conditional two's-complement negation, modulo 2^W.
module div_negate
  import div_pkg::*;
#(
  parameter int W = DEF_XLEN
) (
  input  logic [W-1:0] in,
  input  logic         en,
  output logic [W-1:0] out
);

  // Pass the value through, or return its two's complement when enabled.
  always_comb begin
    if (en) begin
      out = ~in + W'(1'b1);
    end else begin
      out = in;
    end
  end

endmodule

// File: rtl/divider_seq.sv
// Iterative radix-2 restoring divider with RISC-V DIV/DIVU/REM/REMU semantics.
// Operands are reduced to magnitudes at start, divided unsigned over XLEN
// cycles, and the signs are re-applied in a single fix-up cycle.
module divider_seq
  import div_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic            sign,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quot,
  output logic [XLEN-1:0] rem,
  output logic            div_zero,
  output logic            overflow
);

  state_t            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [XLEN:0]     rem_p_r;    // partial remainder, one extra bit for the trial sign
  logic [XLEN-1:0]   q_r;        // dividend shifting out, quotient shifting in
  logic [XLEN-1:0]   b_mag_r;
  logic [XLEN-1:0]   a_r;        // raw dividend, returned as remainder on divide-by-zero
  logic              neg_q_r;
  logic              neg_r_r;
  logic              ovf_r;
  logic              div0_r;

  logic [XLEN-1:0]   a_mag_s;
  logic [XLEN-1:0]   b_mag_s;
  logic [XLEN-1:0]   quot_fix_s;
  logic [XLEN-1:0]   rem_fix_s;
  logic [XLEN+1:0]   shift_s;
  logic [XLEN+1:0]   diff_s;

  div_negate #(.W(XLEN)) u_neg_a (
    .in  (a),
    .en  (sign & a[XLEN-1]),
    .out (a_mag_s)
  );

  div_negate #(.W(XLEN)) u_neg_b (
    .in  (b),
    .en  (sign & b[XLEN-1]),
    .out (b_mag_s)
  );

  div_negate #(.W(XLEN)) u_neg_q (
    .in  (q_r),
    .en  (neg_q_r),
    .out (quot_fix_s)
  );

  div_negate #(.W(XLEN)) u_neg_r (
    .in  (rem_p_r[XLEN-1:0]),
    .en  (neg_r_r),
    .out (rem_fix_s)
  );

  // Shift the next dividend bit into the partial remainder and trial-subtract the divisor.
  always_comb begin
    shift_s = {rem_p_r, q_r[XLEN-1]};
    diff_s  = shift_s - {2'b00, b_mag_r};
  end

  // Control FSM, iteration counter, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      rem_p_r  <= '0;
      q_r      <= '0;
      b_mag_r  <= '0;
      a_r      <= '0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      ovf_r    <= 1'b0;
      div0_r   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      quot     <= '0;
      rem      <= '0;
      div_zero <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          // kill is ignored here, so start wins when both are high
          if (start) begin
            a_r     <= a;
            q_r     <= a_mag_s;
            b_mag_r <= b_mag_s;
            rem_p_r <= '0;
            cnt_r   <= CNT_W'(XLEN);
            neg_q_r <= sign & (a[XLEN-1] ^ b[XLEN-1]);
            neg_r_r <= sign & a[XLEN-1];
            ovf_r   <= sign & (a == XLEN'(INT_MIN)) & (b == XLEN'(DIV0_QUOT));
            div0_r  <= (b == {XLEN{1'b0}});
            busy    <= 1'b1;
            if (b == {XLEN{1'b0}}) begin
              state_r <= DONE;
            end else begin
              state_r <= CALC;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          if (kill) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end else begin
            if (!diff_s[XLEN+1]) begin
              rem_p_r <= diff_s[XLEN:0];
              q_r     <= {q_r[XLEN-2:0], 1'b1};
            end else begin
              rem_p_r <= shift_s[XLEN:0];
              q_r     <= {q_r[XLEN-2:0], 1'b0};
            end
            cnt_r <= cnt_r - CNT_W'(1);
            if (cnt_r == CNT_W'(1)) begin
              state_r <= FIX;
            end else begin
              state_r <= CALC;
            end
          end
        end
        FIX: begin
          if (kill) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end else begin
            quot     <= quot_fix_s;
            rem      <= rem_fix_s;
            overflow <= ovf_r;
            div_zero <= 1'b0;
            state_r  <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= IDLE;
          if (div0_r) begin
            quot     <= XLEN'(DIV0_QUOT);
            rem      <= a_r;
            div_zero <= 1'b1;
            overflow <= 1'b0;
          end else begin
            div_zero <= div_zero;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq: directed edge cases, handshake,
// abort and reset scenarios, then randomized operands against a 64-bit
// arithmetic reference.
module tb_divider_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        kill;
  logic        sign;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] quot;
  logic [31:0] rem;
  logic        div_zero;
  logic        overflow;

  int vectors;
  int miscompares;

  logic [31:0] last_q;
  logic [31:0] last_r;
  logic        last_z;
  logic        last_o;

  divider_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .kill     (kill),
    .sign     (sign),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .quot     (quot),
    .rem      (rem),
    .div_zero (div_zero),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: truncating division in 64-bit arithmetic, RISC-V zero-divisor rule.
  function automatic void model(input logic s, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] eq, output logic [31:0] er,
                                output logic ez, output logic eo);
    longint sa, sb, lq, lr;
    if (y == 32'd0) begin
      eq = 32'hFFFF_FFFF;
      er = x;
      ez = 1'b1;
      eo = 1'b0;
    end else begin
      if (s) begin
        sa = longint'($signed(x));
        sb = longint'($signed(y));
      end else begin
        sa = longint'({32'h0, x});
        sb = longint'({32'h0, y});
      end
      lq = sa / sb;
      lr = sa % sb;
      eq = lq[31:0];
      er = lr[31:0];
      ez = 1'b0;
      eo = s && (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    end
  endfunction

  // Called just after a falling edge. inj>0 raises a stray start at that cycle.
  task automatic do_op(input logic s, input logic [31:0] x, input logic [31:0] y, input int inj);
    logic [31:0] eq, er;
    logic        ez, eo;
    int          lat, busy_bad, exp_lat;
    bit          got;
    model(s, x, y, eq, er, ez, eo);
    exp_lat = (y == 32'd0) ? 1 : 34;
    sign  = s;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    lat = 0;
    got = 1'b0;
    busy_bad = 0;
    while (!got && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done) got = 1'b1;
      else if (!busy) busy_bad++;
      if (inj > 0) begin
        if (lat == inj) begin
          start = 1'b1;
          a     = $urandom;
          b     = $urandom;
          sign  = ~s;
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk("done_seen", 32'(got), 32'd1);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("busy_high_until_done", 32'(busy_bad), 32'd0);
    chk("busy_low_at_done", 32'(busy), 32'd0);
    chk("quot", quot, eq);
    chk("rem", rem, er);
    chk("div_zero", 32'(div_zero), 32'(ez));
    chk("overflow", 32'(overflow), 32'(eo));
    last_q = eq;
    last_r = er;
    last_z = ez;
    last_o = eo;
  endtask

  initial begin
    int done_cnt;
    logic [31:0] ra, rb;
    logic        rs;
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    start = 1'b0;
    kill  = 1'b0;
    sign  = 1'b0;
    a     = 32'd0;
    b     = 32'd0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quot", quot, 32'd0);
    chk("rst_rem", rem, 32'd0);
    chk("rst_div_zero", 32'(div_zero), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic and signed cases
    do_op(1'b0, 32'd100, 32'd7, 0);
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(1'b1, 32'd7, 32'hFFFF_FFFE, 0);

    // Divide by zero in both sign modes
    do_op(1'b0, 32'h1234_5678, 32'd0, 0);
    do_op(1'b1, 32'h1234_5678, 32'd0, 0);

    // Signed overflow and its unsigned counterpart
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);

    // Stray start at cycle 10 must not disturb the result
    do_op(1'b0, 32'd1000, 32'd10, 10);

    // Start during the final busy cycle is ignored
    do_op(1'b1, 32'hDEAD_BEEF, 32'h0000_0123, 33);
    @(posedge clk);
    @(negedge clk);
    chk("late_start_busy", 32'(busy), 32'd0);
    chk("late_start_done", 32'(done), 32'd0);

    // Back-to-back: second start raised while done is high
    do_op(1'b0, 32'd55, 32'd5, 0);
    do_op(1'b0, 32'd56, 32'd5, 0);

    // Kill at cycle 20: no done, previous result kept
    do_op(1'b0, 32'hABCD_EF01, 32'd3, 0);
    sign  = 1'b1;
    a     = 32'h7FFF_0000;
    b     = 32'd9;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
    end
    kill = 1'b1;
    @(posedge clk);
    @(negedge clk);
    kill = 1'b0;
    chk("kill_busy", 32'(busy), 32'd0);
    done_cnt = 0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("kill_no_done", 32'(done_cnt), 32'd0);
    chk("kill_quot_kept", quot, last_q);
    chk("kill_rem_kept", rem, last_r);
    chk("kill_div_zero_kept", 32'(div_zero), 32'(last_z));
    chk("kill_overflow_kept", 32'(overflow), 32'(last_o));

    // Asynchronous reset in the middle of an operation
    sign  = 1'b0;
    a     = 32'hFFFF_FFFF;
    b     = 32'd3;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (15) begin
      @(posedge clk);
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_quot", quot, 32'd0);
    chk("arst_rem", rem, 32'd0);
    chk("arst_div_zero", 32'(div_zero), 32'd0);
    chk("arst_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("arst_no_done", 32'(done_cnt), 32'd0);
    do_op(1'b1, 32'hFFFF_FF9C, 32'd7, 0);

    // Randomized operands with nonzero divisor
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 255));
      if ($urandom_range(0, 7) == 0) rb = ~rb + 32'd1;
      if (rb == 32'd0) rb = 32'd1;
      do_op(rs, ra, rb, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
